// File: rtl/tracer_tx_if.sv
// uDMA TX-side tracer interface: fetches L2 words over the TX channel and
// streams them to the trace debugger through a credit-limited prefetch FIFO.
module tracer_tx_if #(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [31:0]               cfg_data_i,
   input  logic [4:0]                cfg_addr_i,
   input  logic                      cfg_valid_i,
   input  logic                      cfg_rw_ni,
   output logic [31:0]               cfg_data_o,
   output logic                      cfg_ready_o,
   output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
   output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
   output logic                      cfg_tx_continuous_o,
   output logic                      cfg_tx_en_o,
   output logic                      cfg_tx_clr_o,
   input  logic                      cfg_tx_en_i,
   input  logic                      cfg_tx_pending_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
   input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
   output logic [1:0]                data_tx_datasize_o,
   output logic                      data_tx_req_o,
   input  logic                      data_tx_gnt_i,
   input  logic [31:0]               data_tx_i,
   input  logic                      data_tx_valid_i,
   output logic                      data_tx_ready_o,
   output logic [31:0]               out_data_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic          hold, hold_nxt;
   logic          cfg_wr, cfg_rd;
   logic [31:0]   rdata;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count, outst, outst_nxt, discard;
   logic          rsp, push, pop, gnt_ok, credit;
   logic          unused_cfg;

   assign cfg_ready_o     = 1'b1;
   assign data_tx_ready_o = 1'b1;
   assign unused_cfg      = ^cfg_data_i;

   assign cfg_wr = cfg_valid_i & ~cfg_rw_ni;
   assign cfg_rd = cfg_valid_i & cfg_rw_ni;

   always_comb begin
      rdata = '0;
      case (cfg_addr_i)
         5'd0: rdata = 32'(cfg_tx_startaddr_o);
         5'd1: rdata = 32'(cfg_tx_size_o);
         5'd2: rdata = {25'd0, 1'b0, cfg_tx_pending_i, cfg_tx_en_i,
                        1'b0, data_tx_datasize_o, cfg_tx_continuous_o};
         5'd3: rdata = 32'(cfg_tx_curr_addr_i);
         5'd4: rdata = 32'(cfg_tx_bytes_left_i);
         5'd5: rdata = {14'd0, state, 8'(outst), 8'(count)};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cfg_data_o          <= '0;
         cfg_tx_startaddr_o  <= '0;
         cfg_tx_size_o       <= '0;
         cfg_tx_continuous_o <= 1'b0;
         data_tx_datasize_o  <= 2'd0;
         cfg_tx_en_o         <= 1'b0;
         cfg_tx_clr_o        <= 1'b0;
      end else begin
         cfg_tx_en_o  <= cfg_wr && (cfg_addr_i == 5'd2) && cfg_data_i[4];
         cfg_tx_clr_o <= cfg_wr && (cfg_addr_i == 5'd2) && cfg_data_i[6];
         if (cfg_wr) begin
            case (cfg_addr_i)
               5'd0: cfg_tx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
               5'd1: cfg_tx_size_o <= cfg_data_i[TRANS_SIZE-1:0];
               5'd2: begin
                  cfg_tx_continuous_o <= cfg_data_i[0];
                  data_tx_datasize_o  <= cfg_data_i[2:1];
               end
               default: ;
            endcase
         end
         if (cfg_rd) cfg_data_o <= rdata;
      end
   end

   // Responses arriving with nothing outstanding (e.g. after a reset) are stale.
   assign rsp         = data_tx_valid_i && (outst != '0);
   assign push        = rsp && (discard == '0) && !cfg_tx_clr_o;
   assign out_valid_o = (count != '0) && (discard == '0);
   assign pop         = out_valid_o && out_ready_i;
   assign out_data_o  = mem[rptr];
   assign gnt_ok      = data_tx_req_o && data_tx_gnt_i;
   assign credit      = ({1'b0, outst} + {1'b0, count}) < DEPTH_W;

   always_comb begin
      outst_nxt = outst;
      if (gnt_ok && !rsp) outst_nxt = outst + CW'(1);
      else if (!gnt_ok && rsp) outst_nxt = outst - CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         outst   <= '0;
         discard <= '0;
      end else begin
         outst <= outst_nxt;
         if (cfg_tx_clr_o) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            discard <= outst_nxt;
         end else begin
            if (push) begin
               mem[wptr] <= data_tx_i;
               wptr      <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (rsp && (discard != '0)) discard <= discard - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         hold  <= 1'b0;
      end else begin
         state <= state_nxt;
         hold  <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (cfg_tx_en_i) state_nxt = FETCH;
         FETCH: if (!cfg_tx_en_i)
                   state_nxt = (outst_nxt != '0) ? DRAIN : IDLE;
         DRAIN: if (outst_nxt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A pending request is held until granted unless the FSM leaves FETCH.
   always_comb begin
      data_tx_req_o = (state == FETCH) && (credit || hold);
      hold_nxt      = data_tx_req_o && !data_tx_gnt_i && (state_nxt == FETCH);
   end

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && !pop && (count == FULL_C)));

endmodule

// File: tb/tb_tracer_tx_if.sv
// Self-checking bench for tracer_tx_if: register table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_tracer_tx_if;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] cfg_data_i = '0;
   logic [4:0]  cfg_addr = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_rw_n = 1'b0;
   logic [31:0] cfg_data_o;
   logic        cfg_ready;
   logic [11:0] startaddr;
   logic [15:0] size;
   logic        cont;
   logic        en_o, clr_o;
   logic        en_i = 1'b0;
   logic        pend_i = 1'b1;
   logic [11:0] curr_addr = 12'hABC;
   logic [15:0] bytes_left = 16'h1234;
   logic [1:0]  dsize;
   logic        req;
   logic        gnt = 1'b0;
   logic [31:0] rdata_in = '0;
   logic        rvalid = 1'b0;
   logic        dready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   tracer_tx_if dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr),
      .cfg_valid_i(cfg_valid), .cfg_rw_ni(cfg_rw_n),
      .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready),
      .cfg_tx_startaddr_o(startaddr), .cfg_tx_size_o(size),
      .cfg_tx_continuous_o(cont), .cfg_tx_en_o(en_o),
      .cfg_tx_clr_o(clr_o), .cfg_tx_en_i(en_i),
      .cfg_tx_pending_i(pend_i), .cfg_tx_curr_addr_i(curr_addr),
      .cfg_tx_bytes_left_i(bytes_left), .data_tx_datasize_o(dsize),
      .data_tx_req_o(req), .data_tx_gnt_i(gnt),
      .data_tx_i(rdata_in), .data_tx_valid_i(rvalid),
      .data_tx_ready_o(dready), .out_data_o(out_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] m_q[$];
   int m_outst, m_disc, m_grants, m_pops;
   bit m_active, m_clr_now, m_clr_pend, m_en_now, m_en_pend;

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;
   resp_t r_q[$];
   int    last_due;
   bit    auto_resp;
   int    fix_lat;

   typedef struct {
      bit          rd;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      r_q.delete();
      m_outst = 0; m_disc = 0; m_grants = 0; m_pops = 0;
      m_active = 0; m_clr_now = 0; m_clr_pend = 0;
      m_en_now = 0; m_en_pend = 0; last_due = 0;
   endfunction

   // One clock: check and update the model at the falling edge, then
   // advance past the rising edge and drive any due L2 response.
   task automatic step();
      bit exp_ov, exp_req;
      int lat, due;
      @(negedge clk);
      exp_ov  = (m_q.size() != 0) && (m_disc == 0);
      exp_req = m_active && ((m_outst + m_q.size()) < DEPTH);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("req", 32'(req), 32'(exp_req));
      chk("clr_pulse", 32'(clr_o), 32'(m_clr_now));
      chk("en_pulse", 32'(en_o), 32'(m_en_now));
      if (exp_ov && out_valid) begin
         chk("out_data", out_data, m_q[0]);
         if (out_ready) begin
            void'(m_q.pop_front());
            m_pops++;
         end
      end
      if (rvalid && m_outst > 0) begin
         m_outst--;
         if (m_disc > 0) m_disc--;
         else m_q.push_back(rdata_in);
      end
      if (req && gnt) begin
         m_outst++;
         m_grants++;
         if (auto_resp) begin
            lat = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 3);
            due = cyc + 1 + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r_q.push_back('{due, $urandom});
         end
      end
      chk("outst_le_depth", 32'(m_outst <= DEPTH), 32'd1);
      if (m_clr_now) begin
         m_q.delete();
         m_disc = m_outst;
      end
      m_clr_now = m_clr_pend; m_clr_pend = 0;
      m_en_now  = m_en_pend;  m_en_pend  = 0;
      m_active  = en_i;
      @(posedge clk);
      cyc++;
      #1;
      if (auto_resp) begin
         if (r_q.size() != 0 && r_q[0].due <= cyc) begin
            rvalid   = 1'b1;
            rdata_in = r_q[0].data;
            void'(r_q.pop_front());
         end else begin
            rvalid = 1'b0;
         end
      end
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      cfg_valid = 1'b1; cfg_rw_n = 1'b0; cfg_addr = a; cfg_data_i = d;
      if (a == 5'd2) begin
         m_en_pend  = d[4];
         m_clr_pend = d[6];
      end
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
      cfg_valid = 1'b1; cfg_rw_n = 1'b1; cfg_addr = a;
      step();
      cfg_valid = 1'b0;
      d = cfg_data_o;
   endtask

   task automatic do_reset();
      rst = 1'b1; en_i = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      out_ready = 1'b0; cfg_valid = 1'b0; auto_resp = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   function automatic void vw(input logic [4:0] a, input logic [31:0] d);
      vt.push_back('{1'b0, a, d, 32'h0});
   endfunction

   function automatic void vr(input logic [4:0] a, input logic [31:0] e);
      vt.push_back('{1'b1, a, 32'h0, e});
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      fix_lat = -1;
      do_reset();

      chk("rst_cfg_data", cfg_data_o, 32'h0);
      chk("rst_req", 32'(req), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_saddr", 32'(startaddr), 32'h0);
      chk("rst_size", 32'(size), 32'h0);
      chk("rst_pulses", 32'({en_o, clr_o, cont, dsize}), 32'h0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);
      chk("rst_data_ready", 32'(dready), 32'h1);

      vw(5'd0, 32'h123);
      vw(5'd1, 32'h40);
      vw(5'd2, 32'h15);
      vr(5'd0, 32'h123);
      vr(5'd1, 32'h40);
      vr(5'd2, 32'h25);
      vr(5'd3, 32'hABC);
      vr(5'd4, 32'h1234);
      vr(5'd5, 32'h0);
      vr(5'd7, 32'h0);
      vw(5'd9, 32'hFFFF_FFFF);
      vr(5'd0, 32'h123);
      vr(5'd1, 32'h40);
      vw(5'd0, 32'hFFFF_F456);
      vr(5'd0, 32'h456);
      vw(5'd2, 32'h40);
      vr(5'd2, 32'h20);
      vr(5'd31, 32'h0);
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].rd) begin
            cfg_read(vt[i].addr, rd);
            chk($sformatf("reg_vec%0d", i), rd, vt[i].exp);
         end else begin
            cfg_write(vt[i].addr, vt[i].wdata);
         end
      end
      chk("tbl_saddr", 32'(startaddr), 32'h456);
      chk("tbl_size", 32'(size), 32'h40);
      chk("tbl_cfg", 32'({cont, dsize}), 32'h0);

      cfg_write(5'd0, 32'h123);
      cfg_write(5'd2, 32'h15);
      chk("t5_en_pulse", 32'(en_o), 32'h1);
      chk("t5_saddr", 32'(startaddr), 32'h123);
      chk("t5_cont", 32'(cont), 32'h1);
      chk("t5_dsize", 32'(dsize), 32'h2);
      step();
      chk("t5_en_fall", 32'(en_o), 32'h0);

      do_reset();
      auto_resp = 1; fix_lat = 1; out_ready = 1'b1; en_i = 1'b1;
      for (int i = 0; i < 80 && m_pops < 8; i++) begin
         gnt = (m_grants < 8);
         step();
      end
      chk("t1_words", 32'(m_pops), 32'd8);
      chk("t1_grants", 32'(m_grants), 32'd8);
      en_i = 1'b0; gnt = 1'b0;
      repeat (4) step();
      cfg_read(5'd5, rd);
      chk("t1_status_idle", rd, 32'h0);

      do_reset();
      auto_resp = 1; fix_lat = 1; out_ready = 1'b0; gnt = 1'b1; en_i = 1'b1;
      repeat (12) step();
      chk("t2_grants", 32'(m_grants), 32'd4);
      chk("t2_req_low", 32'(req), 32'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      repeat (8) step();
      chk("t2_grants_pop", 32'(m_grants), 32'd5);
      chk("t2_pops", 32'(m_pops), 32'd1);

      do_reset();
      fix_lat = -1; en_i = 1'b1;
      step();
      gnt = 1'b1; step(); step();
      gnt = 1'b0; rvalid = 1'b1;
      rdata_in = 32'hA0A0_0001; step();
      rdata_in = 32'hA0A0_0002; step();
      rvalid = 1'b0; gnt = 1'b1; step();
      rvalid = 1'b1; rdata_in = 32'hA0A0_0003; step();
      gnt = 1'b0; rvalid = 1'b0;
      chk("t3_req_drop", 32'(req), 32'h0);
      cfg_read(5'd5, rd);
      chk("t3_status", rd, 32'h0001_0103);
      rvalid = 1'b1; rdata_in = 32'hA0A0_0004; step();
      rvalid = 1'b0;
      cfg_read(5'd5, rd);
      chk("t3_status_full", rd, 32'h0001_0004);
      out_ready = 1'b1;
      repeat (5) step();
      chk("t3_pops", 32'(m_pops), 32'd4);

      out_ready = 1'b0;
      gnt = 1'b1; step(); step();
      gnt = 1'b0; rvalid = 1'b1;
      rdata_in = 32'hB0B0_0005; step();
      rdata_in = 32'hB0B0_0006; step();
      rvalid = 1'b0; gnt = 1'b1; step(); step();
      gnt = 1'b0;
      cfg_write(5'd2, 32'h40);
      step();
      chk("t4_ov_after_clr", 32'(out_valid), 32'h0);
      out_ready = 1'b1; rvalid = 1'b1;
      rdata_in = 32'hDEAD_0007; step();
      rdata_in = 32'hDEAD_0008; step();
      rvalid = 1'b0;
      chk("t4_dropped", 32'(out_valid), 32'h0);
      gnt = 1'b1; step();
      gnt = 1'b0; rvalid = 1'b1; rdata_in = 32'hC0C0_0009; step();
      rvalid = 1'b0;
      chk("t4_stream_valid", 32'(out_valid), 32'h1);
      chk("t4_stream_data", out_data, 32'hC0C0_0009);
      step();

      do_reset();
      cfg_write(5'd0, 32'hABC);
      cfg_read(5'd0, rd);
      en_i = 1'b1;
      step();
      gnt = 1'b1; step();
      gnt = 1'b0; rvalid = 1'b1; rdata_in = 32'hE0E0_0001; step();
      rvalid = 1'b0; gnt = 1'b1; step(); step(); step();
      gnt = 1'b0;
      chk("t6_pre_ov", 32'(out_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("t6_req", 32'(req), 32'h0);
      chk("t6_ov", 32'(out_valid), 32'h0);
      chk("t6_saddr", 32'(startaddr), 32'h0);
      chk("t6_cfg_data", cfg_data_o, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0; en_i = 1'b0;
      model_reset();
      rvalid = 1'b1; rdata_in = 32'hBAD0_0000;
      repeat (3) step();
      rvalid = 1'b0;
      chk("t6_stale", 32'(out_valid), 32'h0);
      cfg_read(5'd5, rd);
      chk("t6_status", rd, 32'h0);

      do_reset();
      auto_resp = 1; fix_lat = -1; en_i = 1'b1;
      for (int i = 0; i < 400; i++) begin
         gnt = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 50);
         if ($urandom_range(0, 39) == 0) cfg_write(5'd2, 32'h40);
         else step();
      end
      en_i = 1'b0; gnt = 1'b0; out_ready = 1'b1;
      repeat (40) step();
      chk("rand_fifo_empty", 32'(m_q.size()), 32'd0);
      chk("rand_outst_zero", 32'(m_outst), 32'd0);
      cfg_read(5'd5, rd);
      chk("rand_status", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
